mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, fixed-latency memory between the CPU's instruction-fetch port and its load/store data port. The arbiter sits between the CPU core and the unified memory. It serialises accesses one at a time, gives data accesses priority, and guarantees fetch progress with a starvation counter. It also honours the core's `clk_en` freeze and rejects misaligned word addresses without touching memory.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `READ_LAT`, default 1: memory read latency in cycles, from `m_en` to valid `m_rdata`. Legal range 1..4.
- `STARVE_LIMIT`, default 4: maximum number of consecutive data grants while fetch is waiting. Legal range 1..15.

Ports:
- `clk`, in, 1: clock.
- `nreset`, in, 1: reset, asynchronous, active-low.
- `clk_en`, in, 1: global advance enable. When low, the block freezes.
- `i_req` in 1, `i_addr` in ADDR_W: fetch request and its address.
- `i_gnt` out 1, `i_valid` out 1, `i_rdata` out DATA_W, `i_err` out 1: fetch grant, response pulse, read data and error flag.
- `d_req` in 1, `d_we` in 1, `d_addr` in ADDR_W, `d_wdata` in DATA_W: data request, write select, address and write data.
- `d_gnt` out 1, `d_valid` out 1, `d_rdata` out DATA_W, `d_err` out 1: data grant, response pulse, read data and error flag.
- `m_en` out 1, `m_we` out 1, `m_addr` out ADDR_W, `m_wdata` out DATA_W: memory access strobe, write select, address and write data.
- `m_rdata` in DATA_W: memory read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. Only one transaction is in flight at a time.
- **IDLE.** When `clk_en` is high and at least one request is high, the arbiter picks a winner and latches the winner's addr/we/wdata and an owner bit. The next state is ISSUE.
- **Winner selection.**
  - Data wins by default.
  - Fetch wins when `d_req` is low.
  - Fetch also wins when `starve_cnt` equals `STARVE_LIMIT` and `i_req` is high.
- **Starvation counter (`starve_cnt`, 4 bits).**
  - Increments on a data grant while `i_req` is high.
  - Clears on any fetch grant, and whenever `i_req` is low at arbitration.
  - Saturates at `STARVE_LIMIT`.
- **ISSUE.** One cycle.
  - `m_en` is high, with `m_addr`, `m_we` and `m_wdata` driven from the latched registers.
  - The owner's `gnt` is high for exactly this cycle. The requester must hold req and its fields stable until it sees `gnt`, then may drop or change them.
  - If the latched `addr[1:0]` is not 0: `m_en` stays low, `gnt` still pulses, and an error flag is latched.
  - Next state is WAIT if `READ_LAT` > 1, otherwise RESP.
- **WAIT.** A counter loads `READ_LAT`-1 and decrements each cycle. The state exits to RESP when the count reaches 1.
- **Read data capture.** `m_rdata` is captured into the owner's rdata register on the clock edge `READ_LAT` cycles after the ISSUE edge.
  - Writes do not update rdata.
  - An error response returns rdata = 0.
- **RESP.** One cycle.
  - The owner's `valid` is high. `err` reflects the latched error flag.
  - Writes complete with `d_valid` as well, so stores are acknowledged uniformly.
  - The next state is IDLE.
- **`clk_en` low.** State, counters and latched registers hold.
  - `m_en`, `gnt` and `valid` are qualified by `clk_en`, so they are low while frozen.
  - No memory access is duplicated or lost.
- **Reset.** Asynchronous, and it may occur mid-transaction.
  - State returns to IDLE, `starve_cnt` to 0, and every output to 0 (including the rdata registers).
  - An in-flight transaction is abandoned with no response.
- **Simultaneous events.** A request present in the RESP cycle is not arbitrated until the IDLE cycle that follows.

## Timing
- Request sampled in IDLE at edge t: ISSUE (`gnt`, `m_en`) occurs in cycle t+1, and `valid` in cycle t+1+`READ_LAT`, with `clk_en` held high.
- Back-to-back throughput is one access per `READ_LAT`+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from req to `gnt`, `m_en` or `valid`.
- `rdata` stays stable from the `valid` cycle until the next response for the same port.

## Structure
- A shared package holds:
  - the state encoding, IDLE=0, ISSUE=1, WAIT=2, RESP=3;
  - owner encoding constants, OWN_I=0, OWN_D=1;
  - the alignment mask constant, 2'b00.
- One natural sub-module: `arb_priority_pick`.
  - Combinational winner selection from `i_req`, `d_req` and `starve_cnt`.
  - Unit-testable on its own.
- The FSM, latency counter and response registers stay in the top module.

## Test plan
- **Fetch only.** `READ_LAT`=1. `i_req`=1, `i_addr`=0x10, memory returns 0xC8000000.
  - `i_gnt` and `m_en` in cycle 1, `i_valid` in cycle 2 with `i_rdata`=0xC8000000.
  - `d_gnt` and `d_valid` never assert.
- **Store.** `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF.
  - `m_we`=1 and `m_wdata`=0xDEADBEEF in ISSUE.
  - `d_valid`=1 and `d_err`=0 one cycle later.
  - `d_rdata` is unchanged.
- **Starvation.** `STARVE_LIMIT`=4, `i_req` and `d_req` held high. The grant order must be D,D,D,D,I,D,D,D,D,I.
- **Misaligned load.** `d_addr`=0x42, `READ_LAT`=3.
  - `m_en` stays low, `d_gnt` pulses.
  - `d_valid`=1 with `d_err`=1 and `d_rdata`=0 three cycles after ISSUE.
- **Freeze.** `READ_LAT`=2 fetch, with `clk_en` dropped for 3 cycles in WAIT.
  - `valid` is delayed by exactly 3 cycles.
  - `m_en` pulses only once.
  - `i_rdata` equals the memory value.
- **Reset mid-operation.** `nreset` asserted during WAIT.
  - All outputs go to 0 immediately.
  - After release, `busy`=0 and no stale `valid` appears.
  - A new fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned LAT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic       OWN_I      = 1'b0;
    localparam logic       OWN_D      = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != ALIGN_MASK;
    endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Winner selection between fetch and data requests; data wins unless fetch is starved.
module arb_priority_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                i_ireq,
    input  logic                i_dreq,
    input  logic [STARVE_W-1:0] i_starve_cnt,
    output logic                o_any_c,
    output logic                o_owner_c
);

    logic w_starved;

    assign w_starved = i_ireq && (i_starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign o_any_c   = i_ireq | i_dreq;
    assign o_owner_c = (i_dreq && !w_starved) ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one fixed-latency memory port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              clk_en,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    state_t              r_state;
    logic                r_owner;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_any;
    logic                w_owner;
    logic                w_last;

    arb_priority_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_ireq       (i_req),
        .i_dreq       (d_req),
        .i_starve_cnt (r_starve_cnt),
        .o_any_c      (w_any),
        .o_owner_c    (w_owner)
    );

    // Last enabled cycle before RESP: memory read data is sampled on its closing edge.
    assign w_last = ((r_state == ST_ISSUE) && (READ_LAT == 1)) ||
                    ((r_state == ST_WAIT) && (r_lat_cnt == LAT_W'(1)));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_req) begin
                        r_starve_cnt <= '0;
                    end
                    if (w_any) begin
                        r_owner <= w_owner;
                        r_state <= ST_ISSUE;
                        if (w_owner == OWN_D) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                            r_err   <= is_misaligned(d_addr[1:0]);
                            if (i_req && (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
                                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                            end
                        end else begin
                            r_addr       <= i_addr;
                            r_we         <= 1'b0;
                            r_wdata      <= '0;
                            r_err        <= is_misaligned(i_addr[1:0]);
                            r_starve_cnt <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (READ_LAT > 1) begin
                        r_state   <= ST_WAIT;
                        r_lat_cnt <= LAT_W'(READ_LAT - 1);
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_lat_cnt == LAT_W'(1)) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Errored accesses return zero; stores leave the owner's read data untouched.
            if (w_last && (r_err || !r_we)) begin
                if (r_owner == OWN_D) begin
                    r_d_rdata <= r_err ? '0 : m_rdata;
                end else begin
                    r_i_rdata <= r_err ? '0 : m_rdata;
                end
            end
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign m_en    = clk_en && (r_state == ST_ISSUE) && !r_err;
    assign m_we    = r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

    assign i_gnt   = clk_en && (r_state == ST_ISSUE) && (r_owner == OWN_I);
    assign d_gnt   = clk_en && (r_state == ST_ISSUE) && (r_owner == OWN_D);
    assign i_valid = clk_en && (r_state == ST_RESP) && (r_owner == OWN_I);
    assign d_valid = clk_en && (r_state == ST_RESP) && (r_owner == OWN_D);
    assign i_err   = (r_state == ST_RESP) && (r_owner == OWN_I) && r_err;
    assign d_err   = (r_state == ST_RESP) && (r_owner == OWN_D) && r_err;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with READ_LAT = 1, 2 and 3 share stimulus.
module tb_mem_port_arbiter;

    localparam int unsigned NI = 3;

    logic        clk = 1'b0;
    logic        nreset;
    logic        clk_en;
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_val;

    logic        i_gnt_v   [NI];
    logic        i_valid_v [NI];
    logic        i_err_v   [NI];
    logic        d_gnt_v   [NI];
    logic        d_valid_v [NI];
    logic        d_err_v   [NI];
    logic        m_en_v    [NI];
    logic        m_we_v    [NI];
    logic        busy_v    [NI];
    logic [31:0] i_rdata_v [NI];
    logic [31:0] d_rdata_v [NI];
    logic [31:0] m_addr_v  [NI];
    logic [31:0] m_wdata_v [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned RL = g + 1;
        logic [31:0] m_rdata;
        logic        r_act;
        logic [2:0]  r_cnt;

        mem_port_arbiter #(
            .ADDR_W       (32),
            .DATA_W       (32),
            .READ_LAT     (RL),
            .STARVE_LIMIT (4)
        ) u_dut (
            .clk     (clk),
            .nreset  (nreset),
            .clk_en  (clk_en),
            .i_req   (i_req),
            .i_addr  (i_addr),
            .i_gnt   (i_gnt_v[g]),
            .i_valid (i_valid_v[g]),
            .i_rdata (i_rdata_v[g]),
            .i_err   (i_err_v[g]),
            .d_req   (d_req),
            .d_we    (d_we),
            .d_addr  (d_addr),
            .d_wdata (d_wdata),
            .d_gnt   (d_gnt_v[g]),
            .d_valid (d_valid_v[g]),
            .d_rdata (d_rdata_v[g]),
            .d_err   (d_err_v[g]),
            .m_en    (m_en_v[g]),
            .m_we    (m_we_v[g]),
            .m_addr  (m_addr_v[g]),
            .m_wdata (m_wdata_v[g]),
            .m_rdata (m_rdata),
            .busy    (busy_v[g])
        );

        // Memory presents mem_val only during the RL-th enabled cycle counted from the m_en cycle.
        always @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                r_act <= 1'b0;
                r_cnt <= 3'd0;
            end else if (clk_en) begin
                if (m_en_v[g]) begin
                    r_act <= (RL > 1);
                    r_cnt <= 3'd1;
                end else if (r_act) begin
                    if (r_cnt == 3'(RL - 1)) r_act <= 1'b0;
                    else r_cnt <= r_cnt + 3'd1;
                end
            end
        end

        assign m_rdata = ((m_en_v[g] && (RL == 1)) || (r_act && (r_cnt == 3'(RL - 1))))
                         ? mem_val : 32'hBAD0_BAD0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        tick();
        tick();
        for (int g = 0; g < NI; g++) begin
            total++;
            if (busy_v[g] !== 1'b0 || i_gnt_v[g] !== 1'b0 || d_gnt_v[g] !== 1'b0 || m_en_v[g] !== 1'b0 ||
                i_valid_v[g] !== 1'b0 || d_valid_v[g] !== 1'b0 || m_we_v[g] !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctrl[%0d] busy=%b ignt=%b dgnt=%b men=%b iv=%b dv=%b mwe=%b, required all 0",
                         g, busy_v[g], i_gnt_v[g], d_gnt_v[g], m_en_v[g], i_valid_v[g], d_valid_v[g], m_we_v[g]);
            end
            total++;
            if (i_rdata_v[g] !== 32'h0 || d_rdata_v[g] !== 32'h0 || m_addr_v[g] !== 32'h0 || m_wdata_v[g] !== 32'h0) begin
                bad++;
                $display("FAIL reset_data[%0d] irdata=%h drdata=%h maddr=%h mwdata=%h, required all 0",
                         g, i_rdata_v[g], d_rdata_v[g], m_addr_v[g], m_wdata_v[g]);
            end
        end
        nreset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_fetch_only();
        mem_val = 32'hC800_0000;
        i_addr  = 32'h0000_0010;
        i_req   = 1'b1;
        tick();
        total++;
        if (i_gnt_v[0] !== 1'b1 || m_en_v[0] !== 1'b1 || d_gnt_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL fetch_issue ignt=%b men=%b dgnt=%b, required 1 1 0", i_gnt_v[0], m_en_v[0], d_gnt_v[0]);
        end
        total++;
        if (m_addr_v[0] !== 32'h10) begin
            bad++;
            $display("FAIL fetch_addr got=%h want=00000010", m_addr_v[0]);
        end
        i_req = 1'b0;
        tick();
        total++;
        if (i_valid_v[0] !== 1'b1 || i_err_v[0] !== 1'b0 || d_valid_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL fetch_valid iv=%b ierr=%b dv=%b, required 1 0 0", i_valid_v[0], i_err_v[0], d_valid_v[0]);
        end
        total++;
        if (i_rdata_v[0] !== 32'hC800_0000) begin
            bad++;
            $display("FAIL fetch_rdata got=%h want=c8000000", i_rdata_v[0]);
        end
        tick();
        total++;
        if (i_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL fetch_done iv=%b busy=%b, required 0 0", i_valid_v[0], busy_v[0]);
        end
        idle_cycles(8);
    endtask

    task automatic test_data_load();
        mem_val = 32'h1234_5678;
        d_addr  = 32'h0000_0044;
        d_we    = 1'b0;
        d_req   = 1'b1;
        tick();
        total++;
        if (d_gnt_v[0] !== 1'b1 || m_en_v[0] !== 1'b1 || m_we_v[0] !== 1'b0 || i_gnt_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL load_issue dgnt=%b men=%b mwe=%b ignt=%b, required 1 1 0 0",
                     d_gnt_v[0], m_en_v[0], m_we_v[0], i_gnt_v[0]);
        end
        d_req = 1'b0;
        tick();
        total++;
        if (d_valid_v[0] !== 1'b1 || d_rdata_v[0] !== 32'h1234_5678 || d_err_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL load_resp dv=%b drdata=%h derr=%b, required 1 12345678 0", d_valid_v[0], d_rdata_v[0], d_err_v[0]);
        end
        idle_cycles(8);
    endtask

    task automatic test_store();
        mem_val = 32'hFFFF_0000;
        d_addr  = 32'h0000_0040;
        d_wdata = 32'hDEAD_BEEF;
        d_we    = 1'b1;
        d_req   = 1'b1;
        tick();
        total++;
        if (m_en_v[0] !== 1'b1 || m_we_v[0] !== 1'b1 || d_gnt_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL store_issue men=%b mwe=%b dgnt=%b, required 1 1 1", m_en_v[0], m_we_v[0], d_gnt_v[0]);
        end
        total++;
        if (m_wdata_v[0] !== 32'hDEAD_BEEF || m_addr_v[0] !== 32'h40) begin
            bad++;
            $display("FAIL store_bus mwdata=%h maddr=%h, required deadbeef 00000040", m_wdata_v[0], m_addr_v[0]);
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        total++;
        if (d_valid_v[0] !== 1'b1 || d_err_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL store_ack dv=%b derr=%b, required 1 0", d_valid_v[0], d_err_v[0]);
        end
        total++;
        if (d_rdata_v[0] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL store_rdata_kept got=%h want=12345678", d_rdata_v[0]);
        end
        idle_cycles(8);
    endtask

    task automatic test_starvation();
        logic [9:0] exp_pat;
        int n;
        int cyc;
        int last;
        exp_pat = 10'b01111_01111;
        n    = 0;
        cyc  = 0;
        last = 0;
        i_addr = 32'h0000_0100;
        d_addr = 32'h0000_0200;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        while (n < 10 && cyc < 60) begin
            tick();
            cyc++;
            if (i_gnt_v[0] === 1'b1 || d_gnt_v[0] === 1'b1) begin
                total++;
                if (d_gnt_v[0] !== exp_pat[n] || i_gnt_v[0] === d_gnt_v[0]) begin
                    bad++;
                    $display("FAIL starve_order grant=%0d dgnt=%b ignt=%b, required dgnt=%b", n, d_gnt_v[0], i_gnt_v[0], exp_pat[n]);
                end
                if (n > 0) begin
                    total++;
                    if (cyc - last != 3) begin
                        bad++;
                        $display("FAIL starve_spacing grant=%0d gap=%0d want=3", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL starve_count grants=%0d want=10", n);
        end
        idle_cycles(8);
    endtask

    task automatic test_misaligned();
        mem_val = 32'h55AA_55AA;
        d_addr  = 32'h0000_0042;
        d_we    = 1'b0;
        d_req   = 1'b1;
        tick();
        total++;
        if (d_gnt_v[2] !== 1'b1 || m_en_v[2] !== 1'b0) begin
            bad++;
            $display("FAIL misalign_issue dgnt=%b men=%b, required 1 0", d_gnt_v[2], m_en_v[2]);
        end
        d_req = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            tick();
            total++;
            if (d_valid_v[2] !== 1'b0 || busy_v[2] !== 1'b1) begin
                bad++;
                $display("FAIL misalign_wait cycle=%0d dv=%b busy=%b, required 0 1", c, d_valid_v[2], busy_v[2]);
            end
        end
        tick();
        total++;
        if (d_valid_v[2] !== 1'b1 || d_err_v[2] !== 1'b1 || d_rdata_v[2] !== 32'h0) begin
            bad++;
            $display("FAIL misalign_resp dv=%b derr=%b drdata=%h, required 1 1 00000000", d_valid_v[2], d_err_v[2], d_rdata_v[2]);
        end
        idle_cycles(8);
    endtask

    task automatic test_freeze();
        int men;
        int vcyc;
        men  = 0;
        vcyc = 0;
        mem_val = 32'hA5A5_0F0F;
        i_addr  = 32'h0000_0020;
        i_req   = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 2) clk_en = 1'b0;
            if (c == 5) clk_en = 1'b1;
            #1;
            if (c == 1) begin
                total++;
                if (i_gnt_v[1] !== 1'b1) begin
                    bad++;
                    $display("FAIL freeze_gnt got=%b want=1", i_gnt_v[1]);
                end
                i_req = 1'b0;
            end
            if (m_en_v[1] === 1'b1) men++;
            if (i_valid_v[1] === 1'b1 && vcyc == 0) begin
                vcyc = c;
                total++;
                if (i_rdata_v[1] !== 32'hA5A5_0F0F) begin
                    bad++;
                    $display("FAIL freeze_rdata got=%h want=a5a50f0f", i_rdata_v[1]);
                end
            end
        end
        total++;
        if (vcyc != 6) begin
            bad++;
            $display("FAIL freeze_valid_cycle got=%0d want=6", vcyc);
        end
        total++;
        if (men != 1) begin
            bad++;
            $display("FAIL freeze_men_pulses got=%0d want=1", men);
        end
        idle_cycles(8);
    endtask

    task automatic test_reset_mid();
        logic stale;
        int vcyc;
        stale = 1'b0;
        vcyc  = 0;
        mem_val = 32'h600D_F00D;
        i_addr  = 32'h0000_0030;
        i_req   = 1'b1;
        tick();
        i_req = 1'b0;
        tick();
        total++;
        if (busy_v[2] !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_inflight busy=%b want=1", busy_v[2]);
        end
        #2;
        nreset = 1'b0;
        #1;
        total++;
        if (busy_v[2] !== 1'b0 || m_en_v[2] !== 1'b0 || i_gnt_v[2] !== 1'b0 || i_valid_v[2] !== 1'b0 ||
            m_addr_v[2] !== 32'h0 || i_rdata_v[2] !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_async busy=%b men=%b ignt=%b iv=%b maddr=%h irdata=%h, required all 0",
                     busy_v[2], m_en_v[2], i_gnt_v[2], i_valid_v[2], m_addr_v[2], i_rdata_v[2]);
        end
        tick();
        tick();
        nreset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (busy_v[2] !== 1'b0 || i_valid_v[2] !== 1'b0 || d_valid_v[2] !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_stale busy/valid seen after release, required none");
        end
        mem_val = 32'h0BAD_CAFE;
        i_addr  = 32'h0000_0034;
        i_req   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) i_req = 1'b0;
            if (i_valid_v[2] === 1'b1 && vcyc == 0) begin
                vcyc = c;
                total++;
                if (i_rdata_v[2] !== 32'h0BAD_CAFE || i_err_v[2] !== 1'b0) begin
                    bad++;
                    $display("FAIL rstmid_refetch irdata=%h ierr=%b, required 0badcafe 0", i_rdata_v[2], i_err_v[2]);
                end
            end
        end
        total++;
        if (vcyc != 4) begin
            bad++;
            $display("FAIL rstmid_refetch_cycle got=%0d want=4", vcyc);
        end
        idle_cycles(4);
    endtask

    initial begin
        nreset  = 1'b0;
        clk_en  = 1'b1;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        i_addr  = 32'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        mem_val = 32'h0;
        test_reset();
        test_fetch_only();
        test_data_load();
        test_store();
        test_starvation();
        test_misaligned();
        test_freeze();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
